// File: rtl/memory_stage.sv
// Memory pipeline stage: issues one data-memory request per load/store and emits one writeback record per instruction.
// Optional MEM_SUBWORD_EN adds byte/half accesses with lane steering and load extension.
module memory_stage #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  exe_valid,
    input  logic                  exe_reg_en,
    input  logic                  exe_mem_read,
    input  logic                  exe_mem_write,
    input  logic [5:0]            exe_reg_waddr,
    input  logic [ADDR_W-1:0]     alu_result_reg,
    input  logic [DATA_W-1:0]     exe_store_data,
`ifdef MEM_SUBWORD_EN
    input  logic [1:0]            exe_mem_size,
    input  logic                  exe_mem_unsigned,
`endif
    output logic                  mem_allowin,
    output logic                  data_req,
    output logic                  data_wr,
    output logic [ADDR_W-1:0]     data_addr,
    output logic [DATA_W/8-1:0]   data_wstrb,
    output logic [DATA_W-1:0]     data_wdata,
    input  logic                  data_addr_ok,
    input  logic                  data_ok,
    input  logic [DATA_W-1:0]     data_rdata,
    output logic                  mem_valid,
    output logic                  mem_reg_en,
    output logic [5:0]            mem_reg_waddr,
    output logic [DATA_W-1:0]     mem_result
);
    localparam int STRB_W = DATA_W / 8;

    typedef enum logic [1:0] {IDLE = 2'd0, ADDR = 2'd1, DATA = 2'd2} state_t;

    state_t              state_r;
    logic                data_req_r;
    logic                data_wr_r;
    logic [ADDR_W-1:0]   data_addr_r;
    logic [STRB_W-1:0]   data_wstrb_r;
    logic [DATA_W-1:0]   data_wdata_r;
    logic                mem_valid_r;
    logic                mem_reg_en_r;
    logic [5:0]          mem_reg_waddr_r;
    logic [DATA_W-1:0]   mem_result_r;
    logic                lat_reg_en_r;
    logic [5:0]          lat_waddr_r;
    logic                lat_load_r;
    logic [DATA_W-1:0]   lat_alu_r;
    logic [ADDR_W-1:0]   req_addr_s;
    logic [STRB_W-1:0]   req_wstrb_s;
    logic [DATA_W-1:0]   req_wdata_s;
    logic [DATA_W-1:0]   load_data_s;
`ifdef MEM_SUBWORD_EN
    logic [1:0]          lat_size_r;
    logic                lat_unsigned_r;
    logic [1:0]          lat_off_r;

    function automatic logic [STRB_W-1:0] sub_strb(input logic [1:0] size, input logic [1:0] off);
        logic [STRB_W-1:0] m;
        case (size)
            2'd0:    m = STRB_W'(1'b1) << off;
            2'd1:    m = STRB_W'(2'b11) << {off[1], 1'b0};
            default: m = {STRB_W{1'b1}};
        endcase
        return m;
    endfunction

    function automatic logic [DATA_W-1:0] sub_wdata(input logic [1:0] size, input logic [DATA_W-1:0] d);
        logic [DATA_W-1:0] r;
        case (size)
            2'd0:    r = {STRB_W{d[7:0]}};
            2'd1:    r = {(DATA_W/16){d[15:0]}};
            default: r = d;
        endcase
        return r;
    endfunction

    // Misaligned halves use off[1] only, i.e. they are aligned down.
    function automatic logic [DATA_W-1:0] sub_load(input logic [DATA_W-1:0] rdata, input logic [1:0] size,
                                                   input logic [1:0] off, input logic uns);
        logic [7:0]        b;
        logic [15:0]       h;
        logic [DATA_W-1:0] r;
        b = 8'(rdata >> {off, 3'b000});
        h = 16'(rdata >> {off[1], 4'b0000});
        case (size)
            2'd0:    r = uns ? {{(DATA_W-8){1'b0}}, b} : {{(DATA_W-8){b[7]}}, b};
            2'd1:    r = uns ? {{(DATA_W-16){1'b0}}, h} : {{(DATA_W-16){h[15]}}, h};
            default: r = rdata;
        endcase
        return r;
    endfunction
`endif

    assign mem_allowin   = (state_r == IDLE);
    assign data_req      = data_req_r;
    assign data_wr       = data_wr_r;
    assign data_addr     = data_addr_r;
    assign data_wstrb    = data_wstrb_r;
    assign data_wdata    = data_wdata_r;
    assign mem_valid     = mem_valid_r;
    assign mem_reg_en    = mem_reg_en_r;
    assign mem_reg_waddr = mem_reg_waddr_r;
    assign mem_result    = mem_result_r;

    // Request fields from the incoming record and load data from the returned word.
    always_comb begin
`ifdef MEM_SUBWORD_EN
        req_addr_s  = alu_result_reg;
        req_wstrb_s = exe_mem_write ? sub_strb(exe_mem_size, alu_result_reg[1:0]) : {STRB_W{1'b0}};
        req_wdata_s = sub_wdata(exe_mem_size, exe_store_data);
        load_data_s = sub_load(data_rdata, lat_size_r, lat_off_r, lat_unsigned_r);
`else
        req_addr_s  = {alu_result_reg[ADDR_W-1:2], 2'b00};
        req_wstrb_s = exe_mem_write ? {STRB_W{1'b1}} : {STRB_W{1'b0}};
        req_wdata_s = exe_store_data;
        load_data_s = data_rdata;
`endif
    end

    // Stage FSM with registered request and writeback outputs.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r         <= IDLE;
            data_req_r      <= 1'b0;
            data_wr_r       <= 1'b0;
            data_addr_r     <= {ADDR_W{1'b0}};
            data_wstrb_r    <= {STRB_W{1'b0}};
            data_wdata_r    <= {DATA_W{1'b0}};
            mem_valid_r     <= 1'b0;
            mem_reg_en_r    <= 1'b0;
            mem_reg_waddr_r <= 6'd0;
            mem_result_r    <= {DATA_W{1'b0}};
            lat_reg_en_r    <= 1'b0;
            lat_waddr_r     <= 6'd0;
            lat_load_r      <= 1'b0;
            lat_alu_r       <= {DATA_W{1'b0}};
`ifdef MEM_SUBWORD_EN
            lat_size_r      <= 2'd0;
            lat_unsigned_r  <= 1'b0;
            lat_off_r       <= 2'd0;
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    if (exe_valid && (exe_mem_read || exe_mem_write)) begin
                        lat_reg_en_r <= exe_reg_en;
                        lat_waddr_r  <= exe_reg_waddr;
                        lat_load_r   <= exe_mem_read & ~exe_mem_write;
                        lat_alu_r    <= DATA_W'(alu_result_reg);
`ifdef MEM_SUBWORD_EN
                        lat_size_r     <= exe_mem_size;
                        lat_unsigned_r <= exe_mem_unsigned;
                        lat_off_r      <= alu_result_reg[1:0];
`endif
                        data_req_r   <= 1'b1;
                        data_wr_r    <= exe_mem_write;
                        data_addr_r  <= req_addr_s;
                        data_wdata_r <= req_wdata_s;
                        data_wstrb_r <= req_wstrb_s;
                        mem_valid_r  <= 1'b0;
                        state_r      <= ADDR;
                    end else if (exe_valid) begin
                        mem_valid_r     <= 1'b1;
                        mem_result_r    <= DATA_W'(alu_result_reg);
                        mem_reg_en_r    <= exe_reg_en;
                        mem_reg_waddr_r <= exe_reg_waddr;
                    end else begin
                        mem_valid_r <= 1'b0;
                    end
                end
                ADDR: begin
                    mem_valid_r <= 1'b0;
                    if (data_addr_ok) begin
                        data_req_r <= 1'b0;
                        state_r    <= DATA;
                    end
                end
                DATA: begin
                    if (data_ok) begin
                        mem_valid_r     <= 1'b1;
                        mem_result_r    <= lat_load_r ? load_data_s : lat_alu_r;
                        mem_reg_en_r    <= lat_reg_en_r;
                        mem_reg_waddr_r <= lat_waddr_r;
                        state_r         <= IDLE;
                    end
                end
                default: begin
                    data_req_r  <= 1'b0;
                    mem_valid_r <= 1'b0;
                    state_r     <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_memory_stage.sv
// Self-checking bench for memory_stage: directed scenarios plus randomized ops against a spec-level model.
module tb_memory_stage;
    logic        clk = 1'b0;
    logic        resetn;
    logic        exe_valid, exe_reg_en, exe_mem_read, exe_mem_write;
    logic [5:0]  exe_reg_waddr;
    logic [31:0] alu_result_reg, exe_store_data;
`ifdef MEM_SUBWORD_EN
    logic [1:0]  exe_mem_size;
    logic        exe_mem_unsigned;
`endif
    logic        mem_allowin, data_req, data_wr;
    logic [31:0] data_addr, data_wdata, data_rdata, mem_result;
    logic [3:0]  data_wstrb;
    logic        data_addr_ok, data_ok, mem_valid, mem_reg_en;
    logic [5:0]  mem_reg_waddr;

    int n_tests = 0;
    int n_fail  = 0;

    int          req_c, low_c, val_c;
    logic [31:0] o_addr, o_wdata, o_result;
    logic [3:0]  o_strb;
    logic        o_wr, o_stable, o_reg_en;
    logic [5:0]  o_waddr;

    always #5 clk = ~clk;

    memory_stage #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .resetn(resetn), .exe_valid(exe_valid), .exe_reg_en(exe_reg_en),
        .exe_mem_read(exe_mem_read), .exe_mem_write(exe_mem_write), .exe_reg_waddr(exe_reg_waddr),
        .alu_result_reg(alu_result_reg), .exe_store_data(exe_store_data),
`ifdef MEM_SUBWORD_EN
        .exe_mem_size(exe_mem_size), .exe_mem_unsigned(exe_mem_unsigned),
`endif
        .mem_allowin(mem_allowin), .data_req(data_req), .data_wr(data_wr), .data_addr(data_addr),
        .data_wstrb(data_wstrb), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
        .data_ok(data_ok), .data_rdata(data_rdata), .mem_valid(mem_valid), .mem_reg_en(mem_reg_en),
        .mem_reg_waddr(mem_reg_waddr), .mem_result(mem_result)
    );

    // Address the memory should see for a given ALU result.
    function automatic logic [31:0] exp_addr(input logic [31:0] a);
`ifdef MEM_SUBWORD_EN
        return a;
`else
        return a & 32'hFFFF_FFFC;
`endif
    endfunction

    // Drives one load/store through accept, address and data phases; reports what was observed.
    task automatic run_mem_op(input logic rd, input logic wr, input logic ren, input logic [5:0] wa,
                              input logic [31:0] alu, input logic [31:0] sd, input logic [31:0] rdata,
                              input int addr_dly, input int data_dly, input logic noise);
        req_c = 0; low_c = 0; val_c = 0; o_stable = 1'b1;
        o_addr = 32'd0; o_strb = 4'd0; o_wdata = 32'd0; o_wr = 1'b0;
        exe_valid = 1'b1; exe_mem_read = rd; exe_mem_write = wr; exe_reg_en = ren;
        exe_reg_waddr = wa; alu_result_reg = alu; exe_store_data = sd;
        @(negedge clk);
        exe_valid = 1'b0; alu_result_reg = $urandom; exe_store_data = $urandom;
        exe_reg_waddr = 6'($urandom); exe_reg_en = 1'($urandom);
        for (int i = 0; i <= addr_dly; i++) begin
            if (data_req) req_c++;
            if (!mem_allowin) low_c++;
            if (mem_valid) val_c++;
            if (i == 0) begin
                o_addr = data_addr; o_strb = data_wstrb; o_wdata = data_wdata; o_wr = data_wr;
            end else if ({data_addr, data_wstrb, data_wdata, data_wr} !== {o_addr, o_strb, o_wdata, o_wr}) begin
                o_stable = 1'b0;
            end
            data_addr_ok = (i == addr_dly); data_ok = noise & 1'($urandom); data_rdata = $urandom;
            @(negedge clk);
        end
        data_addr_ok = 1'b0; data_ok = 1'b0;
        for (int i = 0; i <= data_dly; i++) begin
            if (data_req) req_c++;
            if (!mem_allowin) low_c++;
            if (mem_valid) val_c++;
            data_ok = (i == data_dly); data_rdata = (i == data_dly) ? rdata : $urandom;
            data_addr_ok = noise & 1'($urandom);
            @(negedge clk);
        end
        data_ok = 1'b0; data_addr_ok = 1'b0;
        if (mem_valid) val_c++;
        if (!mem_allowin) low_c++;
        if (data_req) req_c++;
        o_result = mem_result; o_waddr = mem_reg_waddr; o_reg_en = mem_reg_en;
        @(negedge clk);
        if (mem_valid) val_c++;
        if (!mem_allowin) low_c++;
        if (data_req) req_c++;
    endtask

    task automatic test_reset();
        resetn = 1'b0; exe_valid = 1'b1; exe_mem_read = 1'b1; exe_mem_write = 1'b0; exe_reg_en = 1'b1;
        exe_reg_waddr = 6'd3; alu_result_reg = 32'h55; exe_store_data = 32'h66;
        data_addr_ok = 1'b1; data_ok = 1'b1; data_rdata = 32'h77;
        repeat (2) @(negedge clk);
        n_tests++;
        if ({data_req, data_wr, data_addr, data_wstrb, data_wdata} !== 70'd0) begin
            n_fail++; $display("FAIL reset_req: got %h expected 0", {data_req, data_wr, data_addr, data_wstrb, data_wdata});
        end
        n_tests++;
        if ({mem_valid, mem_reg_en, mem_reg_waddr, mem_result} !== 40'd0) begin
            n_fail++; $display("FAIL reset_wb: got %h expected 0", {mem_valid, mem_reg_en, mem_reg_waddr, mem_result});
        end
        n_tests++;
        if (mem_allowin !== 1'b1) begin n_fail++; $display("FAIL reset_allowin: got %b expected 1", mem_allowin); end
        exe_valid = 1'b0; exe_mem_read = 1'b0; data_addr_ok = 1'b0; data_ok = 1'b0;
        resetn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_nonmem();
        exe_valid = 1'b1; exe_mem_read = 1'b0; exe_mem_write = 1'b0; exe_reg_en = 1'b1;
        exe_reg_waddr = 6'd5; alu_result_reg = 32'h0000_1234;
        @(negedge clk);
        exe_valid = 1'b0;
        n_tests++;
        if ({mem_valid, mem_reg_en, mem_reg_waddr, mem_result} !== {1'b1, 1'b1, 6'd5, 32'h1234}) begin
            n_fail++; $display("FAIL nonmem_wb: got %h expected %h", {mem_valid, mem_reg_en, mem_reg_waddr, mem_result}, {1'b1, 1'b1, 6'd5, 32'h1234});
        end
        n_tests++;
        if (mem_allowin !== 1'b1 || data_req !== 1'b0) begin
            n_fail++; $display("FAIL nonmem_allowin: got allowin=%b req=%b expected 1/0", mem_allowin, data_req);
        end
        @(negedge clk);
        n_tests++;
        if (mem_valid !== 1'b0) begin n_fail++; $display("FAIL nonmem_pulse: got %b expected 0", mem_valid); end
    endtask

    task automatic test_load();
        run_mem_op(1'b1, 1'b0, 1'b1, 6'd7, 32'h100, 32'h1111_2222, 32'hDEAD_BEEF, 0, 1, 1'b0);
        n_tests++;
        if (req_c !== 1 || low_c !== 3 || val_c !== 1) begin
            n_fail++; $display("FAIL load_timing: got req=%0d low=%0d valid=%0d expected 1/3/1", req_c, low_c, val_c);
        end
        n_tests++;
        if ({o_addr, o_strb, o_wr} !== {32'h100, 4'h0, 1'b0}) begin
            n_fail++; $display("FAIL load_request: got %h/%h/%b expected 100/0/0", o_addr, o_strb, o_wr);
        end
        n_tests++;
        if ({o_result, o_waddr, o_reg_en} !== {32'hDEAD_BEEF, 6'd7, 1'b1}) begin
            n_fail++; $display("FAIL load_wb: got %h/%0d/%b expected deadbeef/7/1", o_result, o_waddr, o_reg_en);
        end
    endtask

    task automatic test_store_delayed();
        run_mem_op(1'b0, 1'b1, 1'b0, 6'd9, 32'h206, 32'hA5A5_A5A5, 32'h1357_9BDF, 4, 0, 1'b1);
        n_tests++;
        if (req_c !== 5 || low_c !== 6 || val_c !== 1 || o_stable !== 1'b1) begin
            n_fail++; $display("FAIL store_timing: got req=%0d low=%0d valid=%0d stable=%b expected 5/6/1/1", req_c, low_c, val_c, o_stable);
        end
        n_tests++;
        if ({o_addr, o_strb, o_wdata, o_wr} !== {exp_addr(32'h206), 4'hF, 32'hA5A5_A5A5, 1'b1}) begin
            n_fail++; $display("FAIL store_request: got %h/%h/%h/%b expected %h/f/a5a5a5a5/1", o_addr, o_strb, o_wdata, o_wr, exp_addr(32'h206));
        end
        n_tests++;
        if ({o_result, o_waddr, o_reg_en} !== {32'h206, 6'd9, 1'b0}) begin
            n_fail++; $display("FAIL store_wb: got %h/%0d/%b expected 206/9/0", o_result, o_waddr, o_reg_en);
        end
    endtask

    task automatic test_reset_mid();
        int vc;
        exe_valid = 1'b1; exe_mem_read = 1'b1; exe_mem_write = 1'b0; exe_reg_en = 1'b1;
        exe_reg_waddr = 6'd12; alu_result_reg = 32'h400;
        @(negedge clk);
        exe_valid = 1'b0; data_addr_ok = 1'b1;
        @(negedge clk);
        data_addr_ok = 1'b0;
        resetn = 1'b0;
        #1;
        n_tests++;
        if ({data_req, data_wr, data_addr, data_wstrb, data_wdata, mem_valid, mem_reg_en, mem_reg_waddr, mem_result} !== 110'd0
            || mem_allowin !== 1'b1) begin
            n_fail++; $display("FAIL midreset_outputs: got req=%b addr=%h result=%h allowin=%b expected zeros/1", data_req, data_addr, mem_result, mem_allowin);
        end
        @(negedge clk);
        resetn = 1'b1; data_ok = 1'b1; data_rdata = 32'hCAFE_F00D;
        @(negedge clk);
        data_ok = 1'b0;
        vc = 0;
        for (int i = 0; i < 3; i++) begin
            if (mem_valid) vc++;
            @(negedge clk);
        end
        n_tests++;
        if (vc !== 0 || mem_allowin !== 1'b1) begin
            n_fail++; $display("FAIL midreset_stale_ok: got valid=%0d allowin=%b expected 0/1", vc, mem_allowin);
        end
    endtask

    task automatic test_back_to_back();
        exe_valid = 1'b1; exe_mem_read = 1'b0; exe_mem_write = 1'b0; exe_reg_en = 1'b1;
        exe_reg_waddr = 6'd1; alu_result_reg = 32'hAAAA_0001;
        @(negedge clk);
        n_tests++;
        if ({mem_valid, mem_result, mem_allowin} !== {1'b1, 32'hAAAA_0001, 1'b1}) begin
            n_fail++; $display("FAIL b2b_first: got %b/%h/%b expected 1/aaaa0001/1", mem_valid, mem_result, mem_allowin);
        end
        exe_reg_waddr = 6'd2; alu_result_reg = 32'hBBBB_0002;
        @(negedge clk);
        n_tests++;
        if ({mem_valid, mem_result, mem_reg_waddr} !== {1'b1, 32'hBBBB_0002, 6'd2}) begin
            n_fail++; $display("FAIL b2b_second: got %b/%h/%0d expected 1/bbbb0002/2", mem_valid, mem_result, mem_reg_waddr);
        end
        exe_mem_read = 1'b1; exe_reg_waddr = 6'd3; alu_result_reg = 32'h300;
        @(negedge clk);
        n_tests++;
        if ({mem_valid, mem_allowin, data_req} !== 3'b001) begin
            n_fail++; $display("FAIL b2b_load_accept: got valid/allowin/req=%b%b%b expected 001", mem_valid, mem_allowin, data_req);
        end
        exe_valid = 1'b0; exe_mem_read = 1'b0; data_addr_ok = 1'b1;
        @(negedge clk);
        data_addr_ok = 1'b0; data_ok = 1'b1; data_rdata = 32'h0BAD_CAFE;
        @(negedge clk);
        data_ok = 1'b0;
        n_tests++;
        if ({mem_valid, mem_result, mem_reg_waddr} !== {1'b1, 32'h0BAD_CAFE, 6'd3}) begin
            n_fail++; $display("FAIL b2b_load_wb: got %b/%h/%0d expected 1/0badcafe/3", mem_valid, mem_result, mem_reg_waddr);
        end
        @(negedge clk);
    endtask

    task automatic test_random();
        logic        rd, wr, ren, ld;
        logic [5:0]  wa;
        logic [31:0] alu, sd, rdat;
        int          kind, ad, dd;
        for (int it = 0; it < 40; it++) begin
            kind = $urandom_range(0, 2);
            rd = 1'($urandom); wr = 1'($urandom); ren = 1'($urandom); wa = 6'($urandom);
            alu = $urandom; sd = $urandom; rdat = $urandom;
            ad = $urandom_range(0, 3); dd = $urandom_range(0, 3);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            if (kind == 0) begin
                exe_valid = 1'b1; exe_mem_read = 1'b0; exe_mem_write = 1'b0; exe_reg_en = ren;
                exe_reg_waddr = wa; alu_result_reg = alu;
                @(negedge clk);
                exe_valid = 1'b0;
                n_tests++;
                if ({mem_valid, mem_reg_en, mem_reg_waddr, mem_result, mem_allowin} !== {1'b1, ren, wa, alu, 1'b1}) begin
                    n_fail++; $display("FAIL rand_nonmem[%0d]: got %b/%b/%0d/%h expected 1/%b/%0d/%h", it, mem_valid, mem_reg_en, mem_reg_waddr, mem_result, ren, wa, alu);
                end
            end else begin
                if (kind == 1) begin rd = 1'b1; wr = 1'b0; end else begin wr = 1'b1; end
                ld = rd & ~wr;
                run_mem_op(rd, wr, ren, wa, alu, sd, rdat, ad, dd, 1'b1);
                n_tests++;
                if (req_c !== ad + 1 || low_c !== ad + dd + 2 || val_c !== 1 || o_stable !== 1'b1) begin
                    n_fail++; $display("FAIL rand_timing[%0d]: got req=%0d low=%0d valid=%0d stable=%b expected %0d/%0d/1/1", it, req_c, low_c, val_c, o_stable, ad + 1, ad + dd + 2);
                end
                n_tests++;
                if ({o_addr, o_strb, o_wdata, o_wr} !== {exp_addr(alu), wr ? 4'hF : 4'h0, sd, wr}) begin
                    n_fail++; $display("FAIL rand_request[%0d]: got %h/%h/%h/%b expected %h/%h/%h/%b", it, o_addr, o_strb, o_wdata, o_wr, exp_addr(alu), wr ? 4'hF : 4'h0, sd, wr);
                end
                n_tests++;
                if ({o_result, o_waddr, o_reg_en} !== {ld ? rdat : alu, wa, ren}) begin
                    n_fail++; $display("FAIL rand_wb[%0d]: got %h/%0d/%b expected %h/%0d/%b", it, o_result, o_waddr, o_reg_en, ld ? rdat : alu, wa, ren);
                end
            end
        end
        @(negedge clk);
    endtask

`ifdef MEM_SUBWORD_EN
    task automatic test_subword();
        exe_mem_size = 2'd0; exe_mem_unsigned = 1'b0;
        run_mem_op(1'b1, 1'b0, 1'b1, 6'd4, 32'h103, 32'd0, 32'h80FF_FFFF, 0, 0, 1'b0);
        n_tests++;
        if (o_result !== 32'hFFFF_FF80 || o_addr !== 32'h103) begin
            n_fail++; $display("FAIL sub_lb_signed: got %h addr %h expected ffffff80 addr 103", o_result, o_addr);
        end
        exe_mem_unsigned = 1'b1;
        run_mem_op(1'b1, 1'b0, 1'b1, 6'd4, 32'h103, 32'd0, 32'h80FF_FFFF, 1, 0, 1'b0);
        n_tests++;
        if (o_result !== 32'h0000_0080) begin n_fail++; $display("FAIL sub_lb_unsigned: got %h expected 00000080", o_result); end
        exe_mem_size = 2'd1; exe_mem_unsigned = 1'b0;
        run_mem_op(1'b1, 1'b0, 1'b1, 6'd4, 32'h103, 32'd0, 32'h8001_0000, 0, 1, 1'b0);
        n_tests++;
        if (o_result !== 32'hFFFF_8001) begin n_fail++; $display("FAIL sub_lh_signed: got %h expected ffff8001", o_result); end
        exe_mem_size = 2'd0;
        run_mem_op(1'b0, 1'b1, 1'b1, 6'd4, 32'h101, 32'h1234_5678, 32'd0, 0, 0, 1'b0);
        n_tests++;
        if ({o_strb, o_wdata} !== {4'b0010, 32'h7878_7878}) begin
            n_fail++; $display("FAIL sub_sb: got %b/%h expected 0010/78787878", o_strb, o_wdata);
        end
        exe_mem_size = 2'd2; exe_mem_unsigned = 1'b0;
    endtask
`endif

    initial begin
        exe_valid = 1'b0; exe_mem_read = 1'b0; exe_mem_write = 1'b0; exe_reg_en = 1'b0;
        exe_reg_waddr = 6'd0; alu_result_reg = 32'd0; exe_store_data = 32'd0;
        data_addr_ok = 1'b0; data_ok = 1'b0; data_rdata = 32'd0; resetn = 1'b0;
`ifdef MEM_SUBWORD_EN
        exe_mem_size = 2'd2; exe_mem_unsigned = 1'b0;
`endif
        test_reset();
        test_nonmem();
        test_load();
        test_store_delayed();
        test_reset_mid();
        test_back_to_back();
`ifdef MEM_SUBWORD_EN
        test_subword();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
